// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - opcode, ALU code and state encodings for the multi-cycle control FSM
package multicycle_ctrl_pkg;

    localparam int OP_W  = 5;
    localparam int ALU_W = 3;
    localparam int ST_W  = 4;

    // R-type occupies 0..7 so a single compare identifies rd-destination ops
    localparam logic [OP_W-1:0] ADD_OP   = 5'd0;
    localparam logic [OP_W-1:0] SUB_OP   = 5'd1;
    localparam logic [OP_W-1:0] SLT_OP   = 5'd2;
    localparam logic [OP_W-1:0] AND_OP   = 5'd3;
    localparam logic [OP_W-1:0] OR_OP    = 5'd4;
    localparam logic [OP_W-1:0] NOR_OP   = 5'd5;
    localparam logic [OP_W-1:0] SLL_OP   = 5'd6;
    localparam logic [OP_W-1:0] SRL_OP   = 5'd7;
    localparam logic [OP_W-1:0] ADDI_OP  = 5'd8;
    localparam logic [OP_W-1:0] SLTI_OP  = 5'd9;
    localparam logic [OP_W-1:0] ANDI_OP  = 5'd10;
    localparam logic [OP_W-1:0] ORI_OP   = 5'd11;
    localparam logic [OP_W-1:0] NORI_OP  = 5'd12;
    localparam logic [OP_W-1:0] SLLI_OP  = 5'd13;
    localparam logic [OP_W-1:0] SRLI_OP  = 5'd14;
    localparam logic [OP_W-1:0] LOAD_OP  = 5'd15;
    localparam logic [OP_W-1:0] STORE_OP = 5'd16;
    localparam logic [OP_W-1:0] BEQ_OP   = 5'd17;
    localparam logic [OP_W-1:0] BNE_OP   = 5'd18;
    localparam logic [OP_W-1:0] J_OP     = 5'd19;

    localparam logic [ALU_W-1:0] ADD_ALU = 3'd0;
    localparam logic [ALU_W-1:0] SUB_ALU = 3'd1;
    localparam logic [ALU_W-1:0] AND_ALU = 3'd2;
    localparam logic [ALU_W-1:0] OR_ALU  = 3'd3;
    localparam logic [ALU_W-1:0] NOR_ALU = 3'd4;
    localparam logic [ALU_W-1:0] SLT_ALU = 3'd5;
    localparam logic [ALU_W-1:0] SLL_ALU = 3'd6;
    localparam logic [ALU_W-1:0] SRL_ALU = 3'd7;

    typedef enum logic [ST_W-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_IS  = 4'd3,
        EXEC_IZ  = 4'd4,
        WB_ALU   = 4'd5,
        MEM_ADDR = 4'd6,
        MEM_RD   = 4'd7,
        MEM_WR   = 4'd8,
        WB_MEM   = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        TRAP     = 4'd12
    } state_t;

    function automatic logic is_rtype(input logic [OP_W-1:0] op);
        return op <= SRL_OP;
    endfunction

    function automatic state_t decode_target(input logic [OP_W-1:0] op);
        case (op)
            ADD_OP, SUB_OP, SLT_OP, AND_OP,
            OR_OP, NOR_OP, SLL_OP, SRL_OP:               return EXEC_R;
            ADDI_OP, SLTI_OP:                            return EXEC_IS;
            ANDI_OP, ORI_OP, NORI_OP, SLLI_OP, SRLI_OP:  return EXEC_IZ;
            LOAD_OP, STORE_OP:                           return MEM_ADDR;
            BEQ_OP, BNE_OP:                              return BRANCH;
            J_OP:                                        return JUMP;
            default:                                     return TRAP;
        endcase
    endfunction

    function automatic logic [ALU_W-1:0] alu_of(input logic [OP_W-1:0] op);
        case (op)
            SUB_OP, BEQ_OP, BNE_OP: return SUB_ALU;
            SLT_OP, SLTI_OP:        return SLT_ALU;
            AND_OP, ANDI_OP:        return AND_ALU;
            OR_OP, ORI_OP:          return OR_ALU;
            NOR_OP, NORI_OP:        return NOR_ALU;
            SLL_OP, SLLI_OP:        return SLL_ALU;
            SRL_OP, SRLI_OP:        return SRL_ALU;
            default:                return ADD_ALU;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control FSM to datapath/memory signal bundle
interface multicycle_ctrl_if;
    import multicycle_ctrl_pkg::*;

    logic [OP_W-1:0]  opcode;
    logic             zero;
    logic             mem_ready;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             ir_write;
    logic             mem_read;
    logic             mem_write;
    logic             iord;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [ALU_W-1:0] alu_ctrl;
    logic [ST_W-1:0]  state;
    logic             illegal;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_src, ir_write, mem_read, mem_write, iord,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               alu_ctrl, state, illegal
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_src, ir_write, mem_read, mem_write, iord,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               alu_ctrl, state, illegal
    );
endinterface

// File: rtl/multicycle_ctrl_next_state.sv
// rtl/multicycle_ctrl_next_state.sv - combinational next-state logic of the control FSM
module ctrl_next_state
    import multicycle_ctrl_pkg::*;
(
    input  state_t          state,
    input  logic [OP_W-1:0] op,
    input  logic            mem_ready,
    output state_t          next
);
    // op is the live opcode in DECODE and the captured op_q everywhere else
    always_comb begin
        next = state;
        case (state)
            FETCH:    next = mem_ready ? DECODE : FETCH;
            DECODE:   next = decode_target(op);
            EXEC_R,
            EXEC_IS,
            EXEC_IZ:  next = WB_ALU;
            MEM_ADDR: next = (op == LOAD_OP) ? MEM_RD : MEM_WR;
            MEM_RD:   next = mem_ready ? WB_MEM : MEM_RD;
            MEM_WR:   next = mem_ready ? FETCH : MEM_WR;
            WB_ALU,
            WB_MEM,
            BRANCH,
            JUMP:     next = FETCH;
            TRAP:     next = TRAP;
            default:  next = FETCH;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle instruction sequencer: state/op registers and strobe decode
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);
    state_t          state_q;
    state_t          state_d;
    logic [OP_W-1:0] op_q;
    logic [OP_W-1:0] op_sel;
    logic            illegal_q;

    assign op_sel = (state_q == DECODE) ? bus.opcode : op_q;

    ctrl_next_state u_next (
        .state     (state_q),
        .op        (op_sel),
        .mem_ready (bus.mem_ready),
        .next      (state_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) op_q <= bus.opcode;
            if (state_d == TRAP) illegal_q <= 1'b1;
        end
    end

    always_comb begin
        bus.pc_write   = 1'b0;
        bus.pc_src     = 2'd0;
        bus.ir_write   = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.iord       = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'd0;
        bus.alu_ctrl   = ADD_ALU;
        case (state_q)
            FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'd1;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            DECODE:   bus.alu_src_b = 2'd2;
            EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.alu_ctrl  = alu_of(op_q);
            end
            EXEC_IS: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
                bus.alu_ctrl  = alu_of(op_q);
            end
            EXEC_IZ: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd3;
                bus.alu_ctrl  = alu_of(op_q);
            end
            WB_ALU: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = is_rtype(op_q);
            end
            MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
            end
            MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
            end
            MEM_WR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
            end
            WB_MEM: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_ctrl  = SUB_ALU;
                bus.pc_src    = 2'd1;
                bus.pc_write  = (op_q == BEQ_OP) ? bus.zero : ~bus.zero;
            end
            JUMP: begin
                bus.pc_src   = 2'd2;
                bus.pc_write = 1'b1;
            end
            default: ;
        endcase
        // Reset forces state to FETCH, whose read strobe must not leak out while rst_n is low
        if (!rst_n) begin
            bus.pc_write = 1'b0;
            bus.ir_write = 1'b0;
            bus.mem_read = 1'b0;
        end
    end

    assign bus.state   = state_q;
    assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for the multi-cycle control FSM
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // strb = {pc_write, ir_write, mem_read, mem_write, reg_write}
    // ext  = {pc_src[1:0], iord, reg_dst, mem_to_reg, illegal}
    typedef struct packed {
        logic [4:0] op;
        logic       mr;
        logic       z;
        logic [3:0] st;
        logic [4:0] strb;
        logic [2:0] alu;
        logic       sel_chk;
        logic       a;
        logic [1:0] b;
        logic [5:0] ext;
        logic [5:0] extm;
    } exp_t;

    exp_t sb[$];

    task automatic push(input logic [4:0] op, input logic mr, input logic z,
                        input logic [3:0] st, input logic [4:0] strb, input logic [2:0] alu,
                        input logic sel_chk, input logic a, input logic [1:0] b,
                        input logic [5:0] ext, input logic [5:0] extm);
        exp_t e;
        e = '{op:op, mr:mr, z:z, st:st, strb:strb, alu:alu, sel_chk:sel_chk,
              a:a, b:b, ext:ext, extm:extm};
        sb.push_back(e);
    endtask

    task automatic push_fetch_decode(input logic [4:0] op);
        push(op, 1'b1, 1'b0, 4'd0, 5'b11100, ADD_ALU, 1'b1, 1'b0, 2'd1, 6'b000000, 6'b111000);
        push(op, 1'b1, 1'b0, 4'd1, 5'b00000, ADD_ALU, 1'b1, 1'b0, 2'd2, 6'b000000, 6'b000000);
    endtask

    // One entry per clock; opcode is only valid on DECODE cycles so later states must rely on op_q
    task automatic drain();
        exp_t e;
        logic [4:0] strb;
        logic [5:0] ext;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            bus.opcode    = (e.st == 4'd1) ? e.op : ~e.op;
            bus.mem_ready = e.mr;
            bus.zero      = e.z;
            #1;
            strb = {bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write};
            ext  = {bus.pc_src, bus.iord, bus.reg_dst, bus.mem_to_reg, bus.illegal};
            total++;
            if (bus.state !== e.st) begin
                bad++;
                $display("FAIL state op=%0d got=%0d want=%0d", e.op, bus.state, e.st);
            end
            total++;
            if (strb !== e.strb) begin
                bad++;
                $display("FAIL strobes op=%0d st=%0d got=%b want=%b", e.op, e.st, strb, e.strb);
            end
            total++;
            if (bus.alu_ctrl !== e.alu) begin
                bad++;
                $display("FAIL alu_ctrl op=%0d st=%0d got=%0d want=%0d", e.op, e.st, bus.alu_ctrl, e.alu);
            end
            if (e.sel_chk) begin
                total++;
                if ({bus.alu_src_a, bus.alu_src_b} !== {e.a, e.b}) begin
                    bad++;
                    $display("FAIL alu_src op=%0d st=%0d got=%b want=%b", e.op, e.st,
                             {bus.alu_src_a, bus.alu_src_b}, {e.a, e.b});
                end
            end
            if (e.extm != 6'd0) begin
                total++;
                if ((ext & e.extm) !== (e.ext & e.extm)) begin
                    bad++;
                    $display("FAIL ext op=%0d st=%0d got=%b want=%b mask=%b", e.op, e.st, ext, e.ext, e.extm);
                end
            end
            total++;
            if (bus.mem_read === 1'b1 && bus.mem_write === 1'b1) begin
                bad++;
                $display("FAIL rd_wr_excl st=%0d got=both want=exclusive", e.st);
            end
        end
    endtask

    task automatic check_reset_state(input string name);
        total++;
        if (bus.state !== 4'd0) begin
            bad++;
            $display("FAIL %s_state got=%0d want=0", name, bus.state);
        end
        total++;
        if ({bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write} !== 5'b0) begin
            bad++;
            $display("FAIL %s_strobes got=%b want=00000", name,
                     {bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write});
        end
        total++;
        if (bus.illegal !== 1'b0) begin
            bad++;
            $display("FAIL %s_illegal got=%b want=0", name, bus.illegal);
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.opcode = '0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 check_reset_state("reset");
        release_reset();
    endtask

    task automatic test_r_type();
        push_fetch_decode(ADD_OP);
        push(ADD_OP, 1'b1, 1'b0, 4'd2, 5'b00000, ADD_ALU, 1'b1, 1'b1, 2'd0, 6'b0, 6'b0);
        push(ADD_OP, 1'b1, 1'b0, 4'd5, 5'b00001, ADD_ALU, 1'b0, 1'b0, 2'd0, 6'b000100, 6'b000110);
        push_fetch_decode(SUB_OP);
        push(SUB_OP, 1'b1, 1'b0, 4'd2, 5'b00000, SUB_ALU, 1'b1, 1'b1, 2'd0, 6'b0, 6'b0);
        push(SUB_OP, 1'b1, 1'b0, 4'd5, 5'b00001, ADD_ALU, 1'b0, 1'b0, 2'd0, 6'b000100, 6'b000110);
        drain();
    endtask

    task automatic test_load_wait();
        push_fetch_decode(LOAD_OP);
        push(LOAD_OP, 1'b1, 1'b0, 4'd6, 5'b00000, ADD_ALU, 1'b1, 1'b1, 2'd2, 6'b0, 6'b0);
        for (int i = 0; i < 3; i++)
            push(LOAD_OP, 1'b0, 1'b0, 4'd7, 5'b00100, ADD_ALU, 1'b0, 1'b0, 2'd0, 6'b001000, 6'b001000);
        push(LOAD_OP, 1'b1, 1'b0, 4'd7, 5'b00100, ADD_ALU, 1'b0, 1'b0, 2'd0, 6'b001000, 6'b001000);
        push(LOAD_OP, 1'b1, 1'b0, 4'd9, 5'b00001, ADD_ALU, 1'b0, 1'b0, 2'd0, 6'b000010, 6'b000110);
        drain();
    endtask

    task automatic test_store_fetch_wait();
        push(STORE_OP, 1'b0, 1'b0, 4'd0, 5'b00100, ADD_ALU, 1'b1, 1'b0, 2'd1, 6'b0, 6'b0);
        push_fetch_decode(STORE_OP);
        push(STORE_OP, 1'b1, 1'b0, 4'd6, 5'b00000, ADD_ALU, 1'b1, 1'b1, 2'd2, 6'b0, 6'b0);
        push(STORE_OP, 1'b1, 1'b0, 4'd8, 5'b00010, ADD_ALU, 1'b0, 1'b0, 2'd0, 6'b001000, 6'b001000);
        drain();
    endtask

    task automatic test_branch();
        logic [4:0] ops [4];
        logic       zs  [4];
        logic [4:0] pw  [4];
        ops = '{BEQ_OP, BEQ_OP, BNE_OP, BNE_OP};
        zs  = '{1'b1, 1'b0, 1'b1, 1'b0};
        pw  = '{5'b10000, 5'b00000, 5'b00000, 5'b10000};
        for (int i = 0; i < 4; i++) begin
            push_fetch_decode(ops[i]);
            push(ops[i], 1'b1, zs[i], 4'd10, pw[i], SUB_ALU, 1'b1, 1'b1, 2'd0, 6'b010000, 6'b110000);
        end
        drain();
    endtask

    task automatic test_imm();
        push_fetch_decode(ORI_OP);
        push(ORI_OP, 1'b1, 1'b0, 4'd4, 5'b00000, OR_ALU, 1'b1, 1'b1, 2'd3, 6'b0, 6'b0);
        push(ORI_OP, 1'b1, 1'b0, 4'd5, 5'b00001, ADD_ALU, 1'b0, 1'b0, 2'd0, 6'b000000, 6'b000110);
        push_fetch_decode(SLTI_OP);
        push(SLTI_OP, 1'b1, 1'b0, 4'd3, 5'b00000, SLT_ALU, 1'b1, 1'b1, 2'd2, 6'b0, 6'b0);
        push(SLTI_OP, 1'b1, 1'b0, 4'd5, 5'b00001, ADD_ALU, 1'b0, 1'b0, 2'd0, 6'b000000, 6'b000110);
        drain();
    endtask

    task automatic test_jump();
        push_fetch_decode(J_OP);
        push(J_OP, 1'b1, 1'b0, 4'd11, 5'b10000, ADD_ALU, 1'b0, 1'b0, 2'd0, 6'b100000, 6'b110000);
        drain();
    endtask

    task automatic test_reset_mid_mem_rd();
        push_fetch_decode(LOAD_OP);
        push(LOAD_OP, 1'b1, 1'b0, 4'd6, 5'b00000, ADD_ALU, 1'b1, 1'b1, 2'd2, 6'b0, 6'b0);
        push(LOAD_OP, 1'b0, 1'b0, 4'd7, 5'b00100, ADD_ALU, 1'b0, 1'b0, 2'd0, 6'b001000, 6'b001000);
        drain();
        rst_n = 1'b0;
        #1 check_reset_state("reset_mem_rd");
        bus.mem_ready = 1'b1;
        release_reset();
    endtask

    task automatic test_trap();
        push_fetch_decode(5'h1F);
        for (int i = 0; i < 10; i++)
            push(5'h1F, 1'b1, 1'b1, 4'd12, 5'b00000, ADD_ALU, 1'b0, 1'b0, 2'd0, 6'b000001, 6'b000001);
        drain();
        rst_n = 1'b0;
        #1 check_reset_state("reset_trap");
        release_reset();
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_load_wait();
        test_store_fetch_wait();
        test_branch();
        test_imm();
        test_jump();
        test_reset_mid_mem_rd();
        test_r_type();
        test_trap();
        test_jump();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main multi-cycle control FSM for the 8-bit CPU. It sequences every instruction through fetch, decode, execute, memory and writeback. Per state it drives the datapath strobes, the ALU operand selects and the 3-bit ALU operation code. It sits between the instruction register (opcode source) and the datapath/memory, and uses the ALU zero flag and a memory ready handshake.

Parameters:
OP_W, 5, opcode width
ALU_W, 3, ALU operation code width
ST_W, 4, state register width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  OP_W  opcode field from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes access this cycle
pc_write  out  1  PC load enable
pc_src  out  2  PC source: 0=ALU result, 1=ALUOut register, 2=jump target
ir_write  out  1  instruction register load
mem_read  out  1  memory read request
mem_write  out  1  memory write request
iord  out  1  address select: 0=PC, 1=ALUOut
reg_write  out  1  register file write enable
reg_dst  out  1  destination: 0=rt (I-type/LOAD), 1=rd (R-type)
mem_to_reg  out  1  writeback data: 0=ALUOut, 1=MDR
alu_src_a  out  1  0=PC, 1=register A
alu_src_b  out  2  0=register B, 1=constant 1, 2=sign-ext imm, 3=zero-ext imm
alu_ctrl  out  ALU_W  ALU operation code, using the shared ALU encodings
state  out  ST_W  current state, for debug and bench
illegal  out  1  sticky, undefined opcode seen

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous, active-low. While rst_n=0: state=FETCH, op_q=0, illegal=0, and every strobe (pc_write, ir_write, mem_read, mem_write, reg_write) is 0.
- Outputs are Moore-decoded from state and op_q. The only exceptions are pc_write/ir_write in FETCH, which are qualified by mem_ready, and pc_write in BRANCH, which is qualified by zero.
- op_q captures opcode on the DECODE cycle. All states after DECODE use op_q.
- States and transitions:
  - FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_ctrl=ADD, pc_src=0. When mem_ready=1: ir_write=1, pc_write=1, go to DECODE. Otherwise hold with no writes.
  - DECODE: alu_src_a=0, alu_src_b=2, alu_ctrl=ADD (branch target into ALUOut).
    - R-type -> EXEC_R
    - ADDI/SLTI -> EXEC_IS
    - ANDI/ORI/NORI/SLLI/SRLI -> EXEC_IZ
    - LOAD/STORE -> MEM_ADDR
    - BEQ/BNE -> BRANCH
    - J -> JUMP
    - anything else -> TRAP
  - EXEC_R: a=1, b=0, alu_ctrl from op_q -> WB_ALU.
  - EXEC_IS: a=1, b=2, alu_ctrl from op_q -> WB_ALU.
  - EXEC_IZ: a=1, b=3, alu_ctrl from op_q -> WB_ALU.
  - WB_ALU: reg_write=1, mem_to_reg=0, reg_dst=1 for R-type and 0 otherwise -> FETCH.
  - MEM_ADDR: a=1, b=2, ADD. LOAD -> MEM_RD, STORE -> MEM_WR.
  - MEM_RD: mem_read=1, iord=1. Hold until mem_ready, then -> WB_MEM.
  - MEM_WR: mem_write=1, iord=1. Hold until mem_ready, then -> FETCH.
  - WB_MEM: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
  - BRANCH: a=1, b=0, alu_ctrl=SUB, pc_src=1. pc_write=zero for BEQ, ~zero for BNE -> FETCH.
  - JUMP: pc_src=2, pc_write=1 -> FETCH.
  - TRAP: illegal=1, all strobes 0. Terminal until reset.
- ALU mapping from op_q:
  - ADD/ADDI/LOAD/STORE = ADD
  - SUB/BEQ/BNE = SUB
  - SLT/SLTI = SLT
  - AND/ANDI = AND
  - OR/ORI = OR
  - NOR/NORI = NOR
  - SLL/SLLI = SLL
  - SRL/SRLI = SRL
  - In states with no ALU use, alu_ctrl=ADD, never X.
- Latency with mem_ready=1 throughout: R/I-type 4 cycles, LOAD 5, STORE 4, BEQ/BNE 3, J 3.
- Boundary cases:
  - Each mem_ready wait cycle adds exactly one cycle.
  - mem_write and mem_read are never both 1 in the same cycle.
  - Reset asserted in any state, including a wait state, returns to FETCH asynchronously.
  - The first rising edge after deassertion performs FETCH.

Decomposition:
- The shared header holds the opcode defines, the ALU code defines and the state encodings (FETCH=0 … TRAP=12).
- Natural sub-module: ctrl_next_state, the combinational next-state logic (state, op_q, mem_ready -> next state). The top holds the state and op_q registers plus the output decode.

Test Plan:
- Reset mid MEM_RD with mem_ready=0: rst_n low -> state=FETCH and all strobes 0 within the same cycle, illegal=0.
- ADD_OP, mem_ready=1: states FETCH, DECODE, EXEC_R, WB_ALU -> alu_ctrl=ADD_ALU in EXEC_R, reg_write=1 and reg_dst=1 in the 4th cycle, then FETCH.
- LOAD_OP with mem_ready low for 3 cycles in MEM_RD -> MEM_RD held 4 cycles, then WB_MEM with mem_to_reg=1 and reg_write=1. Total 8 cycles.
- BEQ_OP: zero=1 -> pc_write=1 and pc_src=1 in BRANCH. Repeat with zero=0 -> pc_write=0. BNE_OP gives the inverse result.
- ORI_OP -> alu_src_b=3 and alu_ctrl=OR_ALU. SLTI_OP -> alu_src_b=2 and alu_ctrl=SLT_ALU.
- Undefined opcode (5'h1F if unassigned) -> TRAP after DECODE, illegal=1, no further strobes across 10 cycles until reset.
